// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and the command-master state encoding.
package axi_lite_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    // Explicit encodings so the debug state output decodes the same in every tool.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } cmd_master_state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite request engine: one command in, one AXI-Lite
// read or write out, one completion back on the response stream.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid && ready; a source never drops valid or changes payload before that
// edge, and the sink may toggle ready freely.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    // command stream
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // response stream
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout_err,
    // AXI-Lite master
    output logic [ADDR_WIDTH-1:0]   m_axi_aw_addr,
    output logic                    m_axi_aw_valid,
    input  logic                    m_axi_aw_ready,
    output logic [DATA_WIDTH-1:0]   m_axi_w_data,
    output logic [DATA_WIDTH/8-1:0] m_axi_w_strb,
    output logic                    m_axi_w_valid,
    input  logic                    m_axi_w_ready,
    input  logic [1:0]              m_axi_b_resp,
    input  logic                    m_axi_b_valid,
    output logic                    m_axi_b_ready,
    output logic [ADDR_WIDTH-1:0]   m_axi_ar_addr,
    output logic                    m_axi_ar_valid,
    input  logic                    m_axi_ar_ready,
    input  logic [DATA_WIDTH-1:0]   m_axi_r_data,
    input  logic [1:0]              m_axi_r_resp,
    input  logic                    m_axi_r_valid,
    output logic                    m_axi_r_ready,
    // debug
    output logic [2:0]              dbg_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WD_WIDTH   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    cmd_master_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

    // All handshake strobes and valid/ready outputs decode from registered state only.
    assign cmd_ready      = (state_q == ST_IDLE);
    assign m_axi_aw_valid = (state_q == ST_WR_REQ) && !aw_done_q;
    assign m_axi_w_valid  = (state_q == ST_WR_REQ) && !w_done_q;
    assign m_axi_b_ready  = (state_q == ST_WR_RESP);
    assign m_axi_ar_valid = (state_q == ST_RD_REQ);
    assign m_axi_r_ready  = (state_q == ST_RD_RESP);
    assign rsp_valid      = (state_q == ST_RSP);

    assign m_axi_aw_addr  = addr_q;
    assign m_axi_ar_addr  = addr_q;
    assign m_axi_w_data   = wdata_q;
    assign m_axi_w_strb   = wstrb_q;
    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign dbg_state      = state_q;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = m_axi_aw_valid && m_axi_aw_ready;
    assign w_hs   = m_axi_w_valid && m_axi_w_ready;
    assign b_hs   = m_axi_b_valid && m_axi_b_ready;
    assign ar_hs  = m_axi_ar_valid && m_axi_ar_ready;
    assign r_hs   = m_axi_r_valid && m_axi_r_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    // Next-state logic: transaction sequencing plus completion capture.
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // Both channels may finish in the same cycle or in either order.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_b_resp;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (ar_hs) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (r_hs) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi_r_data;
                    rsp_resp_d  = m_axi_r_resp;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, channel-done flags and response fields; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Command payload is latched on acceptance and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_hs) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);
            logic [WD_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
            logic                wd_busy;
            logic                err_q;

            assign wd_busy = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                             (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

            // Count waiting cycles of the current transaction, saturating at the limit.
            always_comb begin
                wd_cnt_d = wd_cnt_q;
                if (cmd_hs) begin
                    wd_cnt_d = '0;
                end else if (wd_busy && !(b_hs || r_hs) && (wd_cnt_q != WD_LIMIT)) begin
                    wd_cnt_d = wd_cnt_q + WD_WIDTH'(1);
                end
            end

            // Flag is sticky: the transaction keeps waiting, only reset clears it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt_q <= '0;
                    err_q    <= 1'b0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                    if (wd_cnt_d == WD_LIMIT) err_q <= 1'b1;
                end
            end

            assign timeout_err = err_q;
        end else begin : g_no_wd
            assign timeout_err = 1'b0;
        end
    endgenerate

endmodule
